prefix_node_core: RTL and testbench
===================================

Name: prefix_node_core

Overview:
- Registered, WIDTH-lane parallel-prefix (Kogge-Stone/Brent-Kung style) combine node for prefix adders.
- Each lane merges a high (more significant) group's generate/propagate with a low group's generate/propagate.
  - gen_out = gen_high | (prop_high & gen_low)
  - prop_out = prop_high & prop_low
- Result is registered behind a single-entry valid/ready stage, so prefix levels chain into a pipelined adder tree.

Parameters:
- WIDTH, 1, number of independent prefix-node lanes (>=1).

Ports:
- clk        input   1      rising-edge clock (the block's single clock)
- rst_n      input   1      asynchronous, active-low reset
- in_valid   input   1      input operands valid this cycle
- in_ready   output  1      stage can accept an operand set this cycle
- gen_high   input   WIDTH  generate of high group, per lane
- gen_low    input   WIDTH  generate of low group, per lane
- prop_high  input   WIDTH  propagate of high group, per lane
- prop_low   input   WIDTH  propagate of low group, per lane
- out_valid  output  1      registered result valid
- out_ready  input   1      downstream accepts result this cycle
- gen_out    output  WIDTH  registered group generate, per lane
- prop_out   output  WIDTH  registered group propagate, per lane

Behaviour:
- Clock and reset: one clock, clk; rst_n is asynchronous and active-low.
- Reset (rst_n=0, asynchronous assert, synchronous-to-clk deassert handled by the system): out_valid=0, gen_out=0, prop_out=0, effective immediately, independent of clk.
- Lane function, bitwise per lane i: gen_next[i] = gen_high[i] | (prop_high[i] & gen_low[i]); prop_next[i] = prop_high[i] & prop_low[i]. There is no cross-lane interaction.
- in_ready = ~out_valid | out_ready. This is combinational; there is no combinational path from in_valid to in_ready.
- Accept: on a rising clk edge with in_valid & in_ready, gen_out/prop_out load gen_next/prop_next and out_valid becomes 1. Latency is exactly 1 cycle.
- Drain: on an edge with out_valid & out_ready & ~in_valid, out_valid becomes 0. gen_out/prop_out hold their last values; they are don't-care to consumers but must not toggle.
- Simultaneous drain and accept (out_valid & out_ready & in_valid): the new result loads and out_valid stays 1. Full throughput is 1 result per cycle.
- Stall (out_valid & ~out_ready): in_ready=0; gen_out, prop_out and out_valid hold stable until accepted. in_valid is ignored.
- in_valid=0 with stage empty: registers unchanged.
- Reset mid-stall or mid-transfer: the pending result is discarded; outputs return to reset values.
- Inputs are sampled only on an accept edge. Input changes at any other time have no effect.

Optional Feature:
- Macro: PREFIX_NODE_COMB_OUT_EN.
- Defined: adds output ports gen_comb [WIDTH] and prop_comb [WIDTH], driven combinationally with gen_next/prop_next (zero latency, unaffected by handshake or reset).
  - Intended for the final prefix level, or for unpipelined use.
- Undefined: those ports do not exist; only registered outputs are present. Registered behaviour is identical in both builds.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with out_valid=1 -> out_valid, gen_out and prop_out go to 0 immediately without a clock edge; in_ready=1.
- Exhaustive truth table, WIDTH=1, out_ready=1: apply all 16 values of {gen_high,gen_low,prop_high,prop_low} from 0000 to 1111, one per cycle. Each result appears 1 cycle later. Spot checks:
  - 0000 -> gen_out=0, prop_out=0
  - 0011 -> gen_out=0, prop_out=1
  - 0110 -> gen_out=1, prop_out=0
  - 0111 -> gen_out=1, prop_out=1
  - 1000 -> gen_out=1, prop_out=0
  - 1111 -> gen_out=1, prop_out=1
- Multi-lane, WIDTH=4: gen_high=0001, gen_low=0110, prop_high=1010, prop_low=1100 -> gen_out=0011, prop_out=1000.
- Backpressure: accept one set, then hold out_ready=0 for 3 cycles while changing the inputs -> in_ready=0 and the outputs stay stable. Raise out_ready with in_valid=1 -> the new result loads the next cycle and out_valid stays 1.
- Throughput: in_valid=1 and out_ready=1 continuously for 8 cycles with distinct operands -> 8 consecutive correct results, out_valid never drops.
- With PREFIX_NODE_COMB_OUT_EN: gen_high=0, gen_low=1, prop_high=1 -> gen_comb=1 in the same cycle; gen_out=1 only after the next edge.

Source files
------------

// File: rtl/prefix_node_core.sv
`default_nettype none
// ============================================================================
// Module      : prefix_node_core
// Description : WIDTH-lane parallel-prefix generate/propagate combine node,
//               registered behind a single-entry valid/ready stage so prefix
//               levels chain into a pipelined adder tree.
//               Optional macro PREFIX_NODE_COMB_OUT_EN adds zero-latency
//               combinational outputs gen_comb/prop_comb.
// Revision    : 1.0 - initial release
// ============================================================================
module prefix_node_core #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] gen_high,
    input  logic [WIDTH-1:0] gen_low,
    input  logic [WIDTH-1:0] prop_high,
    input  logic [WIDTH-1:0] prop_low,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gen_out,
    output logic [WIDTH-1:0] prop_out
`ifdef PREFIX_NODE_COMB_OUT_EN
    ,
    output logic [WIDTH-1:0] gen_comb,
    output logic [WIDTH-1:0] prop_comb
`endif
);

    logic [WIDTH-1:0] gen_next;
    logic [WIDTH-1:0] prop_next;
    logic             accept;

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] gen_q;
    logic [WIDTH-1:0] gen_d;
    logic [WIDTH-1:0] prop_q;
    logic [WIDTH-1:0] prop_d;

    // Per-lane group combine; lanes are fully independent.
    always_comb begin
        gen_next  = gen_high | (prop_high & gen_low);
        prop_next = prop_high & prop_low;
    end

    // Stage can take a new set when empty or when its result leaves this cycle.
    always_comb begin
        in_ready = ~valid_q | out_ready;
        accept   = in_valid & in_ready;
    end

    // Next-state: load on accept, clear valid on a plain drain, else hold.
    // Data registers only move on accept so they never toggle after a drain.
    always_comb begin
        valid_d = valid_q;
        gen_d   = gen_q;
        prop_d  = prop_q;
        if (accept) begin
            valid_d = 1'b1;
            gen_d   = gen_next;
            prop_d  = prop_next;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Result register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            gen_q   <= '0;
            prop_q  <= '0;
        end else begin
            valid_q <= valid_d;
            gen_q   <= gen_d;
            prop_q  <= prop_d;
        end
    end

    assign out_valid = valid_q;
    assign gen_out   = gen_q;
    assign prop_out  = prop_q;

`ifdef PREFIX_NODE_COMB_OUT_EN
    // Zero-latency taps for the final prefix level or unpipelined use.
    assign gen_comb  = gen_next;
    assign prop_comb = prop_next;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prefix_node_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_prefix_node_core
// Description : Self-checking bench for prefix_node_core (WIDTH=4), using a
//               behavioural single-slot model of the registered stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prefix_node_core;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] gen_high;
    logic [W-1:0] gen_low;
    logic [W-1:0] prop_high;
    logic [W-1:0] prop_low;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] gen_out;
    logic [W-1:0] prop_out;
`ifdef PREFIX_NODE_COMB_OUT_EN
    logic [W-1:0] gen_comb;
    logic [W-1:0] prop_comb;
`endif

    int checks;
    int failures;

    // Reference model state: contents of the single output slot.
    logic         m_valid;
    logic [W-1:0] m_gen;
    logic [W-1:0] m_prop;

    prefix_node_core #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .gen_high  (gen_high),
        .gen_low   (gen_low),
        .prop_high (prop_high),
        .prop_low  (prop_low),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gen_out   (gen_out),
        .prop_out  (prop_out)
`ifdef PREFIX_NODE_COMB_OUT_EN
        ,
        .gen_comb  (gen_comb),
        .prop_comb (prop_comb)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Group generate: high group generates, or it propagates a low-group carry.
    function automatic logic [W-1:0] ref_gen(input logic [W-1:0] gh, input logic [W-1:0] gl,
                                             input logic [W-1:0] ph);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            if (gh[i] == 1'b1)                       r[i] = 1'b1;
            else if (ph[i] == 1'b1 && gl[i] == 1'b1) r[i] = 1'b1;
            else                                     r[i] = 1'b0;
        end
        return r;
    endfunction

    // Group propagate: both halves must propagate.
    function automatic logic [W-1:0] ref_prop(input logic [W-1:0] ph, input logic [W-1:0] pl);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++)
            r[i] = (ph[i] == 1'b1 && pl[i] == 1'b1) ? 1'b1 : 1'b0;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check ready/comb, then check registered state.
    task automatic cycle(input logic [W-1:0] gh, input logic [W-1:0] gl,
                         input logic [W-1:0] ph, input logic [W-1:0] pl,
                         input logic iv, input logic ordy);
        logic acc;
        @(negedge clk);
        gen_high  = gh;
        gen_low   = gl;
        prop_high = ph;
        prop_low  = pl;
        in_valid  = iv;
        out_ready = ordy;
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || ordy)});
`ifdef PREFIX_NODE_COMB_OUT_EN
        chk("gen_comb", {28'd0, gen_comb}, {28'd0, ref_gen(gh, gl, ph)});
        chk("prop_comb", {28'd0, prop_comb}, {28'd0, ref_prop(ph, pl)});
`endif
        acc = iv && (!m_valid || ordy);
        @(posedge clk);
        #1;
        if (acc) begin
            m_valid = 1'b1;
            m_gen   = ref_gen(gh, gl, ph);
            m_prop  = ref_prop(ph, pl);
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("gen_out", {28'd0, gen_out}, {28'd0, m_gen});
        chk("prop_out", {28'd0, prop_out}, {28'd0, m_prop});
    endtask

    task automatic rand_cycle(input logic iv, input logic ordy);
        logic [31:0] r;
        r = $urandom;
        cycle(r[3:0], r[7:4], r[11:8], r[15:12], iv, ordy);
    endtask

    // Drop reset mid-cycle (no clock edge) and confirm immediate clear.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        m_valid = 1'b0;
        m_gen   = '0;
        m_prop  = '0;
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_gen"}, {28'd0, gen_out}, 32'd0);
        chk({tag, "_prop"}, {28'd0, prop_out}, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] tt_gen;
        logic [15:0] tt_prop;
        logic [3:0]  v;
        int          bound;

        checks    = 0;
        failures  = 0;
        m_valid   = 1'b0;
        m_gen     = '0;
        m_prop    = '0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        gen_high  = '0;
        gen_low   = '0;
        prop_high = '0;
        prop_low  = '0;

        // Reset state.
        #12;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_gen", {28'd0, gen_out}, 32'd0);
        chk("rst_prop", {28'd0, prop_out}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Truth table {gh,gl,ph,pl}=v broadcast to all lanes, with fixed expectations.
        tt_gen  = 16'hFFC0;
        tt_prop = 16'h8888;
        for (int i = 0; i < 16; i++) begin
            v = i[3:0];
            cycle({W{v[3]}}, {W{v[2]}}, {W{v[1]}}, {W{v[0]}}, 1'b1, 1'b1);
            chk("tt_gen", {28'd0, gen_out}, {28'd0, {W{tt_gen[i]}}});
            chk("tt_prop", {28'd0, prop_out}, {28'd0, {W{tt_prop[i]}}});
        end

        // Multi-lane directed vector.
        cycle(4'b0001, 4'b0110, 4'b1010, 4'b1100, 1'b1, 1'b1);
        chk("ml_gen", {28'd0, gen_out}, 32'h3);
        chk("ml_prop", {28'd0, prop_out}, 32'h8);

        // Backpressure: stall three cycles with changing inputs, then drain+accept.
        rand_cycle(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) rand_cycle(1'b1, 1'b0);
        rand_cycle(1'b1, 1'b1);

        // Drain, then idle while empty.
        rand_cycle(1'b0, 1'b1);
        rand_cycle(1'b0, 1'b0);
        rand_cycle(1'b0, 1'b1);

        // Full throughput run.
        for (int i = 0; i < 8; i++) begin
            rand_cycle(1'b1, 1'b1);
            chk("tp_valid", {31'd0, out_valid}, 32'd1);
        end

        // Random handshake traffic.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] r;
            r = $urandom;
            rand_cycle(r[0], r[1] | r[2]);
        end

        // Reset while stalled with a pending result.
        cycle(4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 1'b1);
        rand_cycle(1'b1, 1'b0);
        async_reset("rst_stall");

`ifdef PREFIX_NODE_COMB_OUT_EN
        // Combinational tap is visible before the register loads.
        @(negedge clk);
        gen_high  = 4'h0;
        gen_low   = 4'hF;
        prop_high = 4'hF;
        prop_low  = 4'h0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("comb_now", {28'd0, gen_comb}, 32'hF);
        chk("comb_reg_before", {28'd0, gen_out}, 32'h0);
        @(posedge clk);
        #1;
        chk("comb_reg_after", {28'd0, gen_out}, 32'hF);
        m_valid = 1'b1;
        m_gen   = 4'hF;
        m_prop  = 4'h0;
`endif

        // Handshake completes within a bounded number of cycles.
        bound = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (out_valid === 1'b1 && bound < 10) begin
            @(posedge clk);
            #1;
            bound++;
        end
        chk("drain_bound", {31'd0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
